// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus widths, load-op encodings and
// the MEM->WB payload bundle.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  typedef enum logic [2:0] {
    LOAD_B  = 3'd0,
    LOAD_BU = 3'd1,
    LOAD_H  = 3'd2,
    LOAD_HU = 3'd3,
    LOAD_W  = 3'd4
  } load_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            gr_we;
    logic [RAW-1:0]  dest;
    logic            res_from_mem;
    logic [2:0]      load_op;
    logic [1:0]      addr_low;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_rdata;
  } ms_ws_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB valid/allowin handshake with its instruction payload.
interface wb_stage_if;
  import cpu_pkg::*;

  logic            ms_to_ws_valid;
  logic            ws_allowin;
  logic [XLEN-1:0] ms_pc;
  logic            ms_gr_we;
  logic [RAW-1:0]  ms_dest;
  logic            ms_res_from_mem;
  logic [2:0]      ms_load_op;
  logic [1:0]      ms_addr_low;
  logic [XLEN-1:0] ms_alu_result;
  logic [XLEN-1:0] ms_mem_rdata;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest,
           ms_res_from_mem, ms_load_op, ms_addr_low,
           ms_alu_result, ms_mem_rdata,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest,
           ms_res_from_mem, ms_load_op, ms_addr_low,
           ms_alu_result, ms_mem_rdata,
    output ws_allowin
  );

endinterface

// File: rtl/load_ext.sv
// Load data extraction: lane select plus sign/zero extension.
module load_ext
  import cpu_pkg::*;
(
  input  logic [2:0]      load_op,
  input  logic [1:0]      addr_low,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (addr_low)
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
  end

  // Misaligned halfwords are trapped upstream, so bit 0 is ignored
  assign lane_h = addr_low[1] ? mem_rdata[31:16]
                              : mem_rdata[15:0];

  always_comb begin
    value = mem_rdata;
    case (load_op)
      LOAD_B:  value = {{24{lane_b[7]}}, lane_b};
      LOAD_BU: value = {24'd0, lane_b};
      LOAD_H:  value = {{16{lane_h[15]}}, lane_h};
      LOAD_HU: value = {16'd0, lane_h};
      default: value = mem_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry pipeline register, load extraction,
// regfile write port, ID bypass and retire trace PC.
module wb_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            ms_to_ws_valid,
  output logic            ws_allowin,
  input  logic [XLEN-1:0] ms_pc,
  input  logic            ms_gr_we,
  input  logic [RAW-1:0]  ms_dest,
  input  logic            ms_res_from_mem,
  input  logic [2:0]      ms_load_op,
  input  logic [1:0]      ms_addr_low,
  input  logic [XLEN-1:0] ms_alu_result,
  input  logic [XLEN-1:0] ms_mem_rdata,
  input  logic            wb_stall,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            ws_fwd_valid,
  output logic [RAW-1:0]  ws_fwd_dest,
  output logic [XLEN-1:0] ws_fwd_data,
  output logic [XLEN-1:0] debug_wb_pc
);

  logic            ws_valid;
  logic            ws_ready_go;
  logic            has_dest;
  ms_ws_t          ws;
  logic [XLEN-1:0] ld_value;

  assign ws_ready_go = !wb_stall;
  assign ws_allowin  = !ws_valid | ws_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws <= '0;
    end else if (ms_to_ws_valid & ws_allowin) begin
      ws <= '{pc:           ms_pc,
              gr_we:        ms_gr_we,
              dest:         ms_dest,
              res_from_mem: ms_res_from_mem,
              load_op:      ms_load_op,
              addr_low:     ms_addr_low,
              alu_result:   ms_alu_result,
              mem_rdata:    ms_mem_rdata};
    end
  end

  load_ext u_load_ext (
    .load_op   (ws.load_op),
    .addr_low  (ws.addr_low),
    .mem_rdata (ws.mem_rdata),
    .value     (ld_value)
  );

  assign has_dest = ws.gr_we & (ws.dest != '0);

  assign rf_we    = ws_valid & ws_ready_go & has_dest;
  assign rf_waddr = ws.dest;
  assign rf_wdata = ws.res_from_mem ? ld_value
                                    : ws.alu_result;

  // Bypass stays visible while stalled so ID can still forward
  assign ws_fwd_valid = ws_valid & has_dest;
  assign ws_fwd_dest  = rf_waddr;
  assign ws_fwd_data  = rf_wdata;

  assign debug_wb_pc = ws_valid ? ws.pc : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected
// regfile writes plus per-scenario inline checks.
module tb_wb_stage;
  import cpu_pkg::*;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_stall = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];

  wb_stage_if bus ();

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_to_ws_valid  (bus.ms_to_ws_valid),
    .ws_allowin      (bus.ws_allowin),
    .ms_pc           (bus.ms_pc),
    .ms_gr_we        (bus.ms_gr_we),
    .ms_dest         (bus.ms_dest),
    .ms_res_from_mem (bus.ms_res_from_mem),
    .ms_load_op      (bus.ms_load_op),
    .ms_addr_low     (bus.ms_addr_low),
    .ms_alu_result   (bus.ms_alu_result),
    .ms_mem_rdata    (bus.ms_mem_rdata),
    .wb_stall        (wb_stall),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .ws_fwd_valid    (ws_fwd_valid),
    .ws_fwd_dest     (ws_fwd_dest),
    .ws_fwd_data     (ws_fwd_data),
    .debug_wb_pc     (debug_wb_pc)
  );

  // Every committed write must match the oldest expected write
  always @(negedge clk) begin
    if (resetn && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: write x%0d=%h, none expected",
                 rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.dest || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL sb_write: got x%0d=%h, expected x%0d=%h",
                   rf_waddr, rf_wdata, e.dest, e.data);
        end
      end
    end
  end

  task automatic set_ms(input logic [31:0] pc, input logic we,
                        input logic [4:0] dest, input logic rfm,
                        input logic [2:0] op, input logic [1:0] al,
                        input logic [31:0] alu,
                        input logic [31:0] rd);
    bus.ms_to_ws_valid  = 1'b1;
    bus.ms_pc           = pc;
    bus.ms_gr_we        = we;
    bus.ms_dest         = dest;
    bus.ms_res_from_mem = rfm;
    bus.ms_load_op      = op;
    bus.ms_addr_low     = al;
    bus.ms_alu_result   = alu;
    bus.ms_mem_rdata    = rd;
  endtask

  // Offer one instruction and step past the accepting edge
  task automatic issue(input logic [31:0] pc, input logic we,
                       input logic [4:0] dest, input logic rfm,
                       input logic [2:0] op, input logic [1:0] al,
                       input logic [31:0] alu,
                       input logic [31:0] rd,
                       input logic exp_w,
                       input logic [31:0] exp_d);
    set_ms(pc, we, dest, rfm, op, al, alu, rd);
    if (exp_w) exp_q.push_back('{dest, exp_d});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ms_to_ws_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.ms_to_ws_valid = 1'b0;
    set_ms(32'h0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
    bus.ms_to_ws_valid = 1'b0;
    resetn = 1'b0;
    #13;
    checks++;
    if (rf_we !== 1'b0 || ws_fwd_valid !== 1'b0 ||
        debug_wb_pc !== 32'h0 || bus.ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset: we=%b fwd=%b pc=%h allowin=%b, expected 0 0 0 1",
               rf_we, ws_fwd_valid, debug_wb_pc, bus.ws_allowin);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rf_we !== 1'b0 || debug_wb_pc !== 32'h0 ||
        bus.ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: we=%b pc=%h allowin=%b, expected 0 0 1",
               rf_we, debug_wb_pc, bus.ws_allowin);
    end
  endtask

  task automatic test_alu();
    issue(32'h1000, 1'b1, 5'd5, 1'b0, LOAD_W, 2'd0,
          32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 ||
        rf_wdata !== 32'h1234_5678 || debug_wb_pc !== 32'h1000 ||
        ws_fwd_valid !== 1'b1 || ws_fwd_dest !== 5'd5 ||
        ws_fwd_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu: we=%b x%0d=%h pc=%h fwd=%b, expected 1 x5=12345678 pc=1000 fwd=1",
               rf_we, rf_waddr, rf_wdata, debug_wb_pc, ws_fwd_valid);
    end
    idle();
    checks++;
    if (rf_we !== 1'b0 || debug_wb_pc !== 32'h0) begin
      errors++;
      $display("FAIL alu_retire: we=%b pc=%h, expected 0 0",
               rf_we, debug_wb_pc);
    end
  endtask

  // Back-to-back loads, one retirement per cycle
  task automatic test_loads();
    logic [31:0] exp_d[8];
    exp_d = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
              32'h0000_7FFF, 32'hFFFF_8001, 32'h80AA_BBCC,
              32'h80AA_BBCC, 32'hFFFF_FFBB};
    issue(32'h2000, 1, 5'd1, 1, LOAD_B,  2'd3, 32'h0,
          32'h80AA_BBCC, 1, exp_d[0]);
    checks++;
    if (rf_wdata !== exp_d[0] || rf_we !== 1'b1) begin
      errors++;
      $display("FAIL lb: got %h we=%b, expected %h we=1",
               rf_wdata, rf_we, exp_d[0]);
    end
    issue(32'h2004, 1, 5'd2, 1, LOAD_BU, 2'd3, 32'h0,
          32'h80AA_BBCC, 1, exp_d[1]);
    checks++;
    if (rf_wdata !== exp_d[1] || debug_wb_pc !== 32'h2004) begin
      errors++;
      $display("FAIL lbu: got %h pc=%h, expected %h pc=2004",
               rf_wdata, debug_wb_pc, exp_d[1]);
    end
    issue(32'h2008, 1, 5'd3, 1, LOAD_H,  2'd2, 32'h0,
          32'h8001_7FFF, 1, exp_d[2]);
    checks++;
    if (rf_wdata !== exp_d[2]) begin
      errors++;
      $display("FAIL lh: got %h, expected %h",
               rf_wdata, exp_d[2]);
    end
    issue(32'h200C, 1, 5'd4, 1, LOAD_HU, 2'd0, 32'h0,
          32'h8001_7FFF, 1, exp_d[3]);
    checks++;
    if (rf_wdata !== exp_d[3]) begin
      errors++;
      $display("FAIL lhu: got %h, expected %h",
               rf_wdata, exp_d[3]);
    end
    issue(32'h2010, 1, 5'd6, 1, LOAD_H,  2'd3, 32'h0,
          32'h8001_7FFF, 1, exp_d[4]);
    checks++;
    if (rf_wdata !== exp_d[4]) begin
      errors++;
      $display("FAIL lh_odd: got %h, expected %h",
               rf_wdata, exp_d[4]);
    end
    issue(32'h2014, 1, 5'd7, 1, LOAD_W,  2'd1, 32'h0,
          32'h80AA_BBCC, 1, exp_d[5]);
    checks++;
    if (rf_wdata !== exp_d[5]) begin
      errors++;
      $display("FAIL lw: got %h, expected %h",
               rf_wdata, exp_d[5]);
    end
    issue(32'h2018, 1, 5'd8, 1, 3'd7,    2'd2, 32'h0,
          32'h80AA_BBCC, 1, exp_d[6]);
    checks++;
    if (rf_wdata !== exp_d[6]) begin
      errors++;
      $display("FAIL undef_op: got %h, expected %h",
               rf_wdata, exp_d[6]);
    end
    issue(32'h201C, 1, 5'd9, 1, LOAD_B,  2'd1, 32'h0,
          32'h80AA_BBCC, 1, exp_d[7]);
    checks++;
    if (rf_wdata !== exp_d[7] || ws_fwd_data !== exp_d[7]) begin
      errors++;
      $display("FAIL lb_lane1: got %h fwd=%h, expected %h",
               rf_wdata, ws_fwd_data, exp_d[7]);
    end
    idle();
  endtask

  task automatic test_dest0();
    issue(32'h3000, 1, 5'd0, 0, LOAD_W, 2'd0, 32'hAAAA_5555,
          32'h0, 0, 32'h0);
    checks++;
    if (rf_we !== 1'b0 || ws_fwd_valid !== 1'b0 ||
        debug_wb_pc !== 32'h3000) begin
      errors++;
      $display("FAIL dest0: we=%b fwd=%b pc=%h, expected 0 0 3000",
               rf_we, ws_fwd_valid, debug_wb_pc);
    end
    issue(32'h3004, 0, 5'd3, 0, LOAD_W, 2'd0, 32'h5555_AAAA,
          32'h0, 0, 32'h0);
    checks++;
    if (rf_we !== 1'b0 || ws_fwd_valid !== 1'b0 ||
        debug_wb_pc !== 32'h3004) begin
      errors++;
      $display("FAIL no_gr_we: we=%b fwd=%b pc=%h, expected 0 0 3004",
               rf_we, ws_fwd_valid, debug_wb_pc);
    end
    idle();
  endtask

  task automatic test_stall();
    wb_stall = 1'b1;
    issue(32'h4000, 1, 5'd10, 0, LOAD_W, 2'd0, 32'hCAFE_0001,
          32'h0, 1, 32'hCAFE_0001);
    // A second instruction waits at the boundary during the stall
    set_ms(32'h4004, 1, 5'd11, 0, LOAD_W, 2'd0, 32'hCAFE_0002,
           32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.ws_allowin !== 1'b0 || rf_we !== 1'b0 ||
          ws_fwd_valid !== 1'b1 || ws_fwd_dest !== 5'd10 ||
          ws_fwd_data !== 32'hCAFE_0001 ||
          debug_wb_pc !== 32'h4000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: allowin=%b we=%b fwd=%b x%0d=%h pc=%h, expected 0 0 1 x10=cafe0001 pc=4000",
                 i, bus.ws_allowin, rf_we, ws_fwd_valid,
                 ws_fwd_dest, ws_fwd_data, debug_wb_pc);
      end
      @(posedge clk);
      #1;
    end
    wb_stall = 1'b0;
    exp_q.push_back('{5'd11, 32'hCAFE_0002});
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd10 ||
        bus.ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: we=%b x%0d allowin=%b, expected 1 x10 1",
               rf_we, rf_waddr, bus.ws_allowin);
    end
    @(posedge clk);
    #1;
    bus.ms_to_ws_valid = 1'b0;
    checks++;
    if (rf_waddr !== 5'd11 || rf_wdata !== 32'hCAFE_0002 ||
        debug_wb_pc !== 32'h4004) begin
      errors++;
      $display("FAIL stall_next: x%0d=%h pc=%h, expected x11=cafe0002 pc=4004",
               rf_waddr, rf_wdata, debug_wb_pc);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    wb_stall = 1'b1;
    issue(32'h5000, 1, 5'd12, 0, LOAD_W, 2'd0, 32'hBAD0_0BAD,
          32'h0, 0, 32'h0);
    bus.ms_to_ws_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (dut.ws_valid !== 1'b0 || rf_we !== 1'b0 ||
        bus.ws_allowin !== 1'b1 || ws_fwd_valid !== 1'b0 ||
        debug_wb_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_stall: valid=%b we=%b allowin=%b fwd=%b pc=%h, expected 0 0 1 0 0",
               dut.ws_valid, rf_we, bus.ws_allowin, ws_fwd_valid,
               debug_wb_pc);
    end
    #2;
    resetn = 1'b1;
    wb_stall = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut.ws_valid !== 1'b0 || rf_we !== 1'b0 ||
        bus.ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_edge: valid=%b we=%b allowin=%b, expected 0 0 1",
               dut.ws_valid, rf_we, bus.ws_allowin);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_dest0();
    test_stall();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain: %0d writes missing, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on rising edge.
  resetn  input  1  asynchronous, active-low reset.
  ms_to_ws_valid  input  1  MEM stage offers an instruction.
  ws_allowin  output  1  WB can accept this cycle.
  ms_pc  input  32  instruction PC.
  ms_gr_we  input  1  instruction writes a GPR.
  ms_dest  input  5  destination GPR index.
  ms_res_from_mem  input  1  result comes from load data, not ALU.
  ms_load_op  input  3  load type (LB, LBU, LH, LHU, LW).
  ms_addr_low  input  2  effective-address bits [1:0].
  ms_alu_result  input  32  ALU result.
  ms_mem_rdata  input  32  raw data-memory word.
  wb_stall  input  1  external hold (trace sink busy).
  rf_we  output  1  register-file write enable.
  rf_waddr  output  5  register-file write index.
  rf_wdata  output  32  register-file write data.
  ws_fwd_valid  output  1  WB holds a pending GPR write, for ID bypass.
  ws_fwd_dest  output  5  bypass destination index.
  ws_fwd_data  output  32  bypass data.
  debug_wb_pc  output  32  PC of the retiring instruction.
REQ-002 SHALL have no parameters; widths fixed as above.

Function
REQ-003 SHALL keep a ws_valid flag plus payload registers (pc, gr_we, dest, res_from_mem, load_op, addr_low, alu_result, mem_rdata).
REQ-004 ws_ready_go SHALL equal !wb_stall; ws_allowin SHALL be !ws_valid | ws_ready_go.
REQ-005 On a rising edge with ws_allowin=1, ws_valid SHALL load ms_to_ws_valid; payload SHALL load only when ms_to_ws_valid & ws_allowin.
REQ-006 With ws_valid=1 and wb_stall=1, all WB registers SHALL hold their values.
REQ-007 rf_we SHALL be ws_valid & ws_ready_go & gr_we & (dest!=0); writes to GPR 0 SHALL be suppressed.
REQ-008 Latency: an instruction accepted on edge N SHALL present rf_we/rf_waddr/rf_wdata during cycle N..N+1, so the regfile write commits on edge N+1 (one cycle if unstalled).
REQ-009 rf_waddr SHALL equal dest; rf_wdata SHALL be alu_result when res_from_mem=0, else the extracted load value.
REQ-010 Load extraction: LW SHALL pass mem_rdata unchanged, ignoring addr_low.
REQ-011 LB/LBU SHALL select byte lane addr_low (0 = bits 7:0 ... 3 = bits 31:24), sign- or zero-extended to 32 bits.
REQ-012 LH/LHU SHALL select halfword lane addr_low[1] (0 = bits 15:0, 1 = bits 31:16), sign- or zero-extended; addr_low[0] SHALL be ignored (alignment faults are raised upstream).
REQ-013 Undefined load_op encodings with res_from_mem=1 SHALL behave as LW.
REQ-014 ws_fwd_valid SHALL be ws_valid & gr_we & (dest!=0), independent of wb_stall; ws_fwd_dest and ws_fwd_data SHALL equal rf_waddr and rf_wdata.
REQ-015 debug_wb_pc SHALL equal the registered pc whenever ws_valid=1, else 0.
REQ-016 Back-to-back accepts SHALL sustain one retirement per cycle with no bubble when wb_stall=0.

Reset
REQ-017 resetn low SHALL asynchronously clear ws_valid and all payload registers to 0.
REQ-018 During and immediately after reset: rf_we=0, ws_fwd_valid=0, debug_wb_pc=0, ws_allowin=1.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction; no write SHALL occur on the following edge.

Structure
REQ-020 Load-op encodings and bus-width constants SHALL live in shared package cpu_pkg.
REQ-021 Load extraction SHALL be a combinational sub-module load_ext (inputs load_op, addr_low, mem_rdata; output 32-bit value).

Verification
REQ-022 ALU op dest=5, alu_result=0x1234_5678, no stall -> one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678.
REQ-023 LB, addr_low=3, mem_rdata=0x80AA_BBCC -> rf_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-024 LH, addr_low=2, mem_rdata=0x8001_7FFF -> 0xFFFF_8001; LHU, addr_low=0 -> 0x0000_7FFF.
REQ-025 Write to dest=0 with gr_we=1 -> rf_we=0, ws_fwd_valid=0, debug_wb_pc still shows pc.
REQ-026 Instruction valid, wb_stall=1 for 3 cycles -> ws_allowin=0, rf_we=0, ws_fwd_valid=1 throughout; exactly one write once stall clears.
REQ-027 resetn pulsed low mid-stall -> ws_valid=0, rf_we=0 on the next edge, ws_allowin=1.
